muldiv_unit: RTL
================

Name: muldiv_unit

Overview:
- Parametrised multi-cycle RV M-extension execution unit; next-generation replacement for the M-extension path of the single-cycle ALU.
- Generalised to XLEN and a configurable multiplier pipeline depth.
- Radix-2 iterative divider with RISC-V-exact divide-by-zero and overflow semantics.
- Tag pass-through so the core can match results to destination registers.
- Sits beside the ALU in the execute stage; the core holds the pipeline while busy is high.

Parameters:
- XLEN, 32: operand and result width (>=8, even).
- MUL_STAGES, 1: multiply latency in cycles (1..4); product register plus MUL_STAGES-1 retiming stages.
- TAG_W, 5: width of the pass-through tag (rd index).

Ports:
- clk  in  1  clock.
- rstn  in  1  reset; synchronous, active-low.
- start  in  1  request; sampled only when busy=0.
- op  in  3  0 mul, 1 mulh, 2 mulhsu, 3 mulhu, 4 div, 5 divu, 6 rem, 7 remu.
- rs1  in  XLEN  operand 1 (dividend / multiplicand).
- rs2  in  XLEN  operand 2 (divisor / multiplier).
- tag_in  in  TAG_W  tag captured with the request.
- flush  in  1  abort any in-flight operation.
- busy  out  1  operation in flight; start ignored.
- completed  out  1  one-cycle pulse; result/tag_out valid.
- result  out  XLEN  result, held until the next completion.
- tag_out  out  TAG_W  tag of the completing request, held like result.

Behaviour:
Reset (rstn=0 at an edge):
- Outputs: completed=0, busy=0, result=0, tag_out=0.
- State returns to IDLE and the iteration counter clears.
- Reset mid-operation discards the operation with no completed pulse.

States: IDLE, MUL, DIV, FIX.

Accept:
- start=1 and busy=0 in cycle T: op, rs1, rs2 and tag_in are latched at the end of T.
- busy=1 from T+1 until the cycle before completed.
- In the completed cycle the unit is IDLE with busy=0, so a start in that cycle is accepted (back-to-back issue).

Multiply (op 0-3):
- Full 2*XLEN-bit product. mulh: signed x signed. mulhsu: signed rs1 x unsigned rs2. mulhu: unsigned x unsigned.
- mul returns the low XLEN bits; the others return the high XLEN bits.
- completed=1 in cycle T+MUL_STAGES.

Divide (op 4-7):
- Fast path, completed in T+1 and no DIV state entered:
  - rs2==0: div/divu -> all ones; rem/remu -> rs1.
  - Signed overflow (rs1 = -2^(XLEN-1), rs2 = -1, op div/rem): div -> rs1; rem -> 0.
- Normal path:
  - DIV: signed ops take operand magnitudes; one restoring quotient bit per cycle, MSB first, for XLEN cycles (T+1..T+XLEN).
  - FIX (cycle T+XLEN+1): quotient negated if the operand signs differ (div only); remainder takes the dividend's sign (rem only).
  - completed=1 in cycle T+XLEN+2.
- Invariant: rs1 = q*rs2 + r, |r| < |rs2|, with XLEN-bit wraparound.

Flush:
- flush=1 at an edge: state -> IDLE, busy -> 0, no completed pulse; result/tag_out keep their old values.
- flush and start in the same cycle: flush wins, start dropped.
- flush in the cycle the completion edge would occur: completion suppressed.
- Reset overrides flush.

Other rules:
- completed is never high for two consecutive cycles for the same request.
- result and tag_out change only on a completion edge.

Test Plan (XLEN=32, MUL_STAGES=1):
- mulh rs1=0x80000000, rs2=0x80000000 at T -> completed in T+1, result=0x40000000; mulhu rs1=rs2=0xFFFFFFFF -> 0xFFFFFFFE; mulhsu rs1=0xFFFFFFFF, rs2=2 -> 0xFFFFFFFF.
- div rs1=-7 (0xFFFFFFF9), rs2=2 at T -> busy in T+1..T+33, completed in T+34, result=0xFFFFFFFD; rem with the same operands -> 0xFFFFFFFF.
- divu rs1=100, rs2=0 -> completed in T+1, result=0xFFFFFFFF; remu -> 100; div 0x80000000 / 0xFFFFFFFF -> 0x80000000 at T+1; rem -> 0.
- divu 1000/7 issued, start pulsed in T+5 with other operands -> ignored; result=142 with tag_out equal to the original tag; a start in the completed cycle is accepted and completes 34 cycles later.
- div in flight, flush at T+10 -> busy=0 at T+11, no completed pulse, result unchanged; rstn=0 at T+10 of a second div -> all outputs 0 at T+11.
- Random 10k ops against a golden model: results match the RISC-V spec; completed pulses match the latency formulas exactly.

Source files
------------

// File: rtl/muldiv_unit.sv
// muldiv_unit: multi-cycle RV M-extension execution unit.
// Multiplies complete after MUL_STAGES cycles through a product register and
// optional retiming stages; divides use a radix-2 restoring loop (one quotient
// bit per cycle) followed by a sign-fix cycle. Divide-by-zero and signed
// overflow are resolved in a single cycle with the RISC-V defined results.
module muldiv_unit #(
  parameter int XLEN       = 32,
  parameter int MUL_STAGES = 1,
  parameter int TAG_W      = 5
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [XLEN-1:0]  rs1,
  input  logic [XLEN-1:0]  rs2,
  input  logic [TAG_W-1:0] tag_in,
  input  logic             flush,
  output logic             busy,
  output logic             completed,
  output logic [XLEN-1:0]  result,
  output logic [TAG_W-1:0] tag_out
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    FIX  = 2'd3
  } state_t;

  // Retiming stages after the product register (at least one slot is kept
  // so the array is never empty when MUL_STAGES is 1).
  localparam int PIPE_N = (MUL_STAGES > 1) ? (MUL_STAGES - 1) : 1;
  localparam int CNT_W  = $clog2(XLEN) + 1;
  localparam logic [CNT_W-1:0] MUL_LAST = (MUL_STAGES > 1) ? CNT_W'(MUL_STAGES - 2) : {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(XLEN - 1);
  localparam logic [XLEN-1:0]  ALL_ONES = {XLEN{1'b1}};
  localparam logic [XLEN-1:0]  INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};

  // mul keeps the low half of the product, mulh/mulhsu/mulhu the high half.
  function automatic logic [XLEN-1:0] sel_product(input logic [2:0] op_f,
                                                  input logic [2*XLEN-1:0] prod_f);
    if (op_f == 3'd0) begin
      return prod_f[XLEN-1:0];
    end else begin
      return prod_f[2*XLEN-1:XLEN];
    end
  endfunction

  // Two's complement magnitude when the operand is treated as signed.
  function automatic logic [XLEN-1:0] magnitude(input logic [XLEN-1:0] val_f,
                                                input logic is_signed_f);
    if (is_signed_f && val_f[XLEN-1]) begin
      return {XLEN{1'b0}} - val_f;
    end else begin
      return val_f;
    end
  endfunction

  state_t               state_r, state_s;
  logic [CNT_W-1:0]     cnt_r, cnt_s;
  logic [2:0]           op_r, op_s;
  logic [TAG_W-1:0]     tag_r, tag_s;
  logic [2*XLEN-1:0]    pipe_r [PIPE_N];
  logic [2*XLEN-1:0]    pipe_s [PIPE_N];
  logic [XLEN-1:0]      quo_r, quo_s;
  logic [XLEN-1:0]      rem_r, rem_s;
  logic [XLEN-1:0]      dvs_r, dvs_s;
  logic                 neg_q_r, neg_q_s;
  logic                 neg_r_r, neg_r_s;
  logic [XLEN-1:0]      result_r, result_s;
  logic [TAG_W-1:0]     tag_out_r, tag_out_s;
  logic                 completed_r, completed_s;
  logic                 busy_r;

  logic [2*XLEN-1:0]    mul_a_s, mul_b_s, product_s;
  logic                 div_signed_s, div_zero_s, div_ovf_s;
  logic [XLEN:0]        rem_shift_s, diff_s;
  logic [XLEN-1:0]      quo_fix_s, rem_fix_s;

  assign mul_a_s   = (op == 3'd1 || op == 3'd2) ? {{XLEN{rs1[XLEN-1]}}, rs1} : {{XLEN{1'b0}}, rs1};
  assign mul_b_s   = (op == 3'd1) ? {{XLEN{rs2[XLEN-1]}}, rs2} : {{XLEN{1'b0}}, rs2};
  assign product_s = mul_a_s * mul_b_s;

  // op 4 (div) and 6 (rem) are signed; 5 and 7 are unsigned.
  assign div_signed_s = op[2] & ~op[0];
  assign div_zero_s   = (rs2 == {XLEN{1'b0}});
  assign div_ovf_s    = div_signed_s && (rs1 == INT_MIN) && (rs2 == ALL_ONES);

  // Restoring step: shift the next dividend bit into the partial remainder.
  assign rem_shift_s = {rem_r, quo_r[XLEN-1]};
  assign diff_s      = rem_shift_s - {1'b0, dvs_r};

  assign quo_fix_s = neg_q_r ? ({XLEN{1'b0}} - quo_r) : quo_r;
  assign rem_fix_s = neg_r_r ? ({XLEN{1'b0}} - rem_r) : rem_r;

  // Next-state and datapath decisions; flush overrides everything but reset.
  always_comb begin
    state_s     = state_r;
    cnt_s       = cnt_r;
    op_s        = op_r;
    tag_s       = tag_r;
    quo_s       = quo_r;
    rem_s       = rem_r;
    dvs_s       = dvs_r;
    neg_q_s     = neg_q_r;
    neg_r_s     = neg_r_r;
    result_s    = result_r;
    tag_out_s   = tag_out_r;
    completed_s = 1'b0;
    for (int i = 0; i < PIPE_N; i++) begin
      pipe_s[i] = pipe_r[i];
    end

    case (state_r)
      IDLE: begin
        if (start) begin
          op_s  = op;
          tag_s = tag_in;
          cnt_s = {CNT_W{1'b0}};
          if (!op[2]) begin
            if (MUL_STAGES == 1) begin
              result_s    = sel_product(op, product_s);
              tag_out_s   = tag_in;
              completed_s = 1'b1;
            end else begin
              pipe_s[0] = product_s;
              state_s   = MUL;
            end
          end else if (div_zero_s) begin
            result_s    = op[1] ? rs1 : ALL_ONES;
            tag_out_s   = tag_in;
            completed_s = 1'b1;
          end else if (div_ovf_s) begin
            result_s    = op[1] ? {XLEN{1'b0}} : rs1;
            tag_out_s   = tag_in;
            completed_s = 1'b1;
          end else begin
            quo_s   = magnitude(rs1, div_signed_s);
            rem_s   = {XLEN{1'b0}};
            dvs_s   = magnitude(rs2, div_signed_s);
            neg_q_s = div_signed_s & (rs1[XLEN-1] ^ rs2[XLEN-1]);
            neg_r_s = div_signed_s & rs1[XLEN-1];
            state_s = DIV;
          end
        end else begin
          state_s = IDLE;
        end
      end
      MUL: begin
        for (int i = 1; i < PIPE_N; i++) begin
          pipe_s[i] = pipe_r[i-1];
        end
        if (cnt_r == MUL_LAST) begin
          result_s    = sel_product(op_r, pipe_r[PIPE_N-1]);
          tag_out_s   = tag_r;
          completed_s = 1'b1;
          state_s     = IDLE;
        end else begin
          cnt_s = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end
      DIV: begin
        if (!diff_s[XLEN]) begin
          rem_s = diff_s[XLEN-1:0];
          quo_s = {quo_r[XLEN-2:0], 1'b1};
        end else begin
          rem_s = rem_shift_s[XLEN-1:0];
          quo_s = {quo_r[XLEN-2:0], 1'b0};
        end
        if (cnt_r == DIV_LAST) begin
          state_s = FIX;
        end else begin
          cnt_s = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end
      FIX: begin
        result_s    = op_r[1] ? rem_fix_s : quo_fix_s;
        tag_out_s   = tag_r;
        completed_s = 1'b1;
        state_s     = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase

    if (flush) begin
      state_s     = IDLE;
      cnt_s       = {CNT_W{1'b0}};
      completed_s = 1'b0;
      result_s    = result_r;
      tag_out_s   = tag_out_r;
    end else begin
      completed_s = completed_s;
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Datapath and output registers.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      cnt_r       <= {CNT_W{1'b0}};
      op_r        <= 3'd0;
      tag_r       <= {TAG_W{1'b0}};
      quo_r       <= {XLEN{1'b0}};
      rem_r       <= {XLEN{1'b0}};
      dvs_r       <= {XLEN{1'b0}};
      neg_q_r     <= 1'b0;
      neg_r_r     <= 1'b0;
      result_r    <= {XLEN{1'b0}};
      tag_out_r   <= {TAG_W{1'b0}};
      completed_r <= 1'b0;
      busy_r      <= 1'b0;
      for (int i = 0; i < PIPE_N; i++) begin
        pipe_r[i] <= {(2*XLEN){1'b0}};
      end
    end else begin
      cnt_r       <= cnt_s;
      op_r        <= op_s;
      tag_r       <= tag_s;
      quo_r       <= quo_s;
      rem_r       <= rem_s;
      dvs_r       <= dvs_s;
      neg_q_r     <= neg_q_s;
      neg_r_r     <= neg_r_s;
      result_r    <= result_s;
      tag_out_r   <= tag_out_s;
      completed_r <= completed_s;
      busy_r      <= (state_s != IDLE);
      for (int i = 0; i < PIPE_N; i++) begin
        pipe_r[i] <= pipe_s[i];
      end
    end
  end

  assign busy      = busy_r;
  assign completed = completed_r;
  assign result    = result_r;
  assign tag_out   = tag_out_r;

endmodule
